// File: rtl/dual_lane_mmio.sv
// Dual-lane memory-mapped I/O block: LED, switch, key and cycle-counter
// registers shared by the EVEN (older) and ODD (younger) pipeline lanes.
module dual_lane_mmio #(
  parameter int SW_W            = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwriteEVEN,
  input  logic            memwriteODD,
  input  logic [31:0]     aluoutEVEN,
  input  logic [31:0]     aluoutODD,
  input  logic [31:0]     writedataEVEN,
  input  logic [31:0]     writedataODD,
  input  logic            key,
  input  logic [SW_W-1:0] sw,
  output logic [31:0]     readioEVEN,
  output logic [31:0]     readioODD,
  output logic            ioselEVEN,
  output logic            ioselODD,
  output logic [15:0]     ledr,
  output logic [7:0]      ledrEVEN,
  output logic [7:0]      ledrODD
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RELEASED, PRESSED} db_state_t;

  logic [15:0]     led_q, led_d;
  logic [7:0]      led_e_q, led_e_d;
  logic [7:0]      led_o_q, led_o_d;
  logic [31:0]     cyc_q, cyc_d;
  logic            sticky_q, sticky_d;
  db_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            key_s1_q, key_s1_d;
  logic            key_s2_q, key_s2_d;
  logic [SW_W-1:0] sw_s1_q, sw_s1_d;
  logic [SW_W-1:0] sw_s2_q, sw_s2_d;

  logic hit_e, hit_o;
  logic st_e, st_o;
  logic led_we_e, led_we_o;
  logic key_we_e, key_we_o;
  logic cyc_we_e, cyc_we_o;
  logic clr, set, pressed;

  // Address decode and per-register store strobes for both lanes
  always_comb begin
    hit_e    = aluoutEVEN[31:4] == 28'hFFFF000;
    hit_o    = aluoutODD[31:4] == 28'hFFFF000;
    st_e     = memwriteEVEN & hit_e;
    st_o     = memwriteODD & hit_o;
    led_we_e = st_e & (aluoutEVEN[3:2] == 2'd0);
    led_we_o = st_o & (aluoutODD[3:2] == 2'd0);
    key_we_e = st_e & (aluoutEVEN[3:2] == 2'd2);
    key_we_o = st_o & (aluoutODD[3:2] == 2'd2);
    cyc_we_e = st_e & (aluoutEVEN[3:2] == 2'd3);
    cyc_we_o = st_o & (aluoutODD[3:2] == 2'd3);
    ioselEVEN = hit_e;
    ioselODD  = hit_o;
  end

  // Key debounce FSM: toggle after DEBOUNCE_CYCLES disagreeing samples
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    set     = 1'b0;
    if (~key_s2_q != (state_q == PRESSED)) begin
      if (cnt_q == CNT_LAST) begin
        state_d = (state_q == PRESSED) ? RELEASED : PRESSED;
        set     = (state_q == RELEASED);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Register next-state: ODD wins store conflicts, set beats clear
  always_comb begin
    led_d    = led_q;
    led_e_d  = led_e_q;
    led_o_d  = led_o_q;
    cyc_d    = cyc_q + 32'd1;
    key_s1_d = key;
    key_s2_d = key_s1_q;
    sw_s1_d  = sw;
    sw_s2_d  = sw_s1_q;
    pressed  = state_q == PRESSED;
    clr      = (key_we_e & writedataEVEN[1]) |
               (key_we_o & writedataODD[1]);
    sticky_d = set ? 1'b1 : (clr ? 1'b0 : sticky_q);
    if (led_we_e) begin
      led_d   = writedataEVEN[15:0];
      led_e_d = writedataEVEN[7:0];
    end
    if (led_we_o) begin
      led_d   = writedataODD[15:0];
      led_o_d = writedataODD[7:0];
    end
    if (cyc_we_e) cyc_d = writedataEVEN;
    if (cyc_we_o) cyc_d = writedataODD;
  end

  // Read muxes; ODD sees EVEN's same-cycle stores, not vice versa
  always_comb begin
    readioEVEN = '0;
    readioODD  = '0;
    if (hit_e) begin
      case (aluoutEVEN[3:2])
        2'd0:    readioEVEN = {16'b0, led_q};
        2'd1:    readioEVEN = 32'(sw_s2_q);
        2'd2:    readioEVEN = {30'b0, sticky_q, pressed};
        default: readioEVEN = cyc_q;
      endcase
    end
    if (hit_o) begin
      case (aluoutODD[3:2])
        2'd0:    readioODD = led_we_e ? {16'b0, writedataEVEN[15:0]}
                                      : {16'b0, led_q};
        2'd1:    readioODD = 32'(sw_s2_q);
        2'd2:    readioODD = {30'b0,
                   sticky_q & ~(key_we_e & writedataEVEN[1]),
                   pressed};
        default: readioODD = cyc_we_e ? writedataEVEN : cyc_q;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      led_e_q  <= '0;
      led_o_q  <= '0;
      cyc_q    <= '0;
      sticky_q <= 1'b0;
      state_q  <= RELEASED;
      cnt_q    <= '0;
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      led_q    <= led_d;
      led_e_q  <= led_e_d;
      led_o_q  <= led_o_d;
      cyc_q    <= cyc_d;
      sticky_q <= sticky_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
    end
  end

  assign ledr     = led_q;
  assign ledrEVEN = led_e_q;
  assign ledrODD  = led_o_q;

endmodule

// File: tb/tb_dual_lane_mmio.sv
// Testbench for dual_lane_mmio: vector table for lane decode/forwarding,
// directed sequences for switch sync, key debounce and reset.
module tb_dual_lane_mmio;

  localparam int SW_W = 4;
  localparam int DB   = 4;
  localparam logic [31:0] A_LED = 32'hFFFF0000;
  localparam logic [31:0] A_SW  = 32'hFFFF0004;
  localparam logic [31:0] A_KEY = 32'hFFFF0008;
  localparam logic [31:0] A_CYC = 32'hFFFF000C;

  logic clk = 1'b0;
  logic reset;
  logic memwriteEVEN, memwriteODD;
  logic [31:0] aluoutEVEN, aluoutODD;
  logic [31:0] writedataEVEN, writedataODD;
  logic key;
  logic [SW_W-1:0] sw;
  logic [31:0] readioEVEN, readioODD;
  logic ioselEVEN, ioselODD;
  logic [15:0] ledr;
  logic [7:0] ledrEVEN, ledrODD;

  dual_lane_mmio #(.SW_W(SW_W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset),
    .memwriteEVEN(memwriteEVEN), .memwriteODD(memwriteODD),
    .aluoutEVEN(aluoutEVEN), .aluoutODD(aluoutODD),
    .writedataEVEN(writedataEVEN), .writedataODD(writedataODD),
    .key(key), .sw(sw),
    .readioEVEN(readioEVEN), .readioODD(readioODD),
    .ioselEVEN(ioselEVEN), .ioselODD(ioselODD),
    .ledr(ledr), .ledrEVEN(ledrEVEN), .ledrODD(ledrODD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we_e;
    logic [31:0] a_e;
    logic [31:0] d_e;
    logic        we_o;
    logic [31:0] a_o;
    logic [31:0] d_o;
    logic        ck_e;
    logic [31:0] x_re;
    logic [31:0] x_ro;
    logic        x_se;
    logic        x_so;
    logic [15:0] x_led;
    logic [7:0]  x_le;
    logic [7:0]  x_lo;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  vec_t vt[16];
  exp_t sbq[$];
  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk(e.nm, act, e.v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memwriteEVEN  = 1'b0;
    memwriteODD   = 1'b0;
    aluoutEVEN    = 32'h0;
    aluoutODD     = 32'h0;
    writedataEVEN = 32'h0;
    writedataODD  = 32'h0;
  endtask

  task automatic rd_e(input string nm, input logic [31:0] a,
                      input logic [31:0] exp);
    memwriteEVEN = 1'b0;
    aluoutEVEN   = a;
    push(nm, exp);
    #1;
    pop_cmp(readioEVEN);
  endtask

  initial begin
    vt[0]  = '{0, A_LED, 0, 0, A_SW, 0,
               1, 0, 32'hA, 1, 1, 16'h0, 8'h0, 8'h0};
    vt[1]  = '{1, A_LED, 32'h0000ABCD, 0, 32'hFFFF0003, 0,
               1, 0, 32'hABCD, 1, 1, 16'h0, 8'h0, 8'h0};
    vt[2]  = '{1, 32'hFFFF0010, 32'h5555, 0, A_LED, 0,
               1, 0, 32'hABCD, 0, 1, 16'hABCD, 8'hCD, 8'h0};
    vt[3]  = '{0, A_LED, 0, 1, 32'h7FFF0000, 32'h9999,
               1, 32'hABCD, 0, 1, 0, 16'hABCD, 8'hCD, 8'h0};
    vt[4]  = '{1, A_LED, 32'h1111, 1, A_LED, 32'h2222,
               1, 32'hABCD, 32'h1111, 1, 1, 16'hABCD, 8'hCD, 8'h0};
    vt[5]  = '{1, A_CYC, 32'h100, 0, A_CYC, 0,
               0, 0, 32'h100, 1, 1, 16'h2222, 8'h11, 8'h22};
    vt[6]  = '{0, A_CYC, 0, 0, A_LED, 0,
               1, 32'h100, 32'h2222, 1, 1, 16'h2222, 8'h11, 8'h22};
    vt[7]  = '{0, A_LED, 0, 1, A_CYC, 32'hFFFFFFFE,
               1, 32'h2222, 32'h101, 1, 1, 16'h2222, 8'h11, 8'h22};
    vt[8]  = '{0, A_CYC, 0, 0, A_CYC, 0,
               1, 32'hFFFFFFFE, 32'hFFFFFFFE, 1, 1,
               16'h2222, 8'h11, 8'h22};
    vt[9]  = '{0, A_CYC, 0, 0, A_CYC, 0,
               1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1,
               16'h2222, 8'h11, 8'h22};
    vt[10] = '{0, A_CYC, 0, 0, A_CYC, 0,
               1, 0, 0, 1, 1, 16'h2222, 8'h11, 8'h22};
    vt[11] = '{1, A_LED, 32'hAA, 1, A_SW, 32'h1234,
               1, 32'h2222, 32'hA, 1, 1, 16'h2222, 8'h11, 8'h22};
    vt[12] = '{0, A_LED, 0, 0, A_SW, 0,
               1, 32'hAA, 32'hA, 1, 1, 16'h00AA, 8'hAA, 8'h22};
    vt[13] = '{0, A_LED, 0, 1, A_LED, 32'hBB,
               1, 32'hAA, 32'hAA, 1, 1, 16'h00AA, 8'hAA, 8'h22};
    vt[14] = '{0, A_LED, 0, 1, A_LED, 32'hCC,
               1, 32'hBB, 32'hBB, 1, 1, 16'h00BB, 8'hAA, 8'hBB};
    vt[15] = '{0, A_LED, 0, 0, A_LED, 0,
               1, 32'hCC, 32'hCC, 1, 1, 16'h00CC, 8'hAA, 8'hCC};

    idle();
    reset = 1'b1;
    key   = 1'b1;
    sw    = 4'hA;
    #1;
    chk("rst_ledr", 32'(ledr), 0);
    chk("rst_ledrE", 32'(ledrEVEN), 0);
    chk("rst_ledrO", 32'(ledrODD), 0);
    rd_e("rst_cyc", A_CYC, 0);
    rd_e("rst_key", A_KEY, 0);
    repeat (3) step();
    reset = 1'b0;
    rd_e("rel_cyc0", A_CYC, 0);
    step();
    rd_e("rel_cyc1", A_CYC, 1);
    step();
    rd_e("rel_cyc2", A_CYC, 2);
    repeat (3) step();

    for (int i = 0; i < 16; i++) begin
      memwriteEVEN  = vt[i].we_e;
      aluoutEVEN    = vt[i].a_e;
      writedataEVEN = vt[i].d_e;
      memwriteODD   = vt[i].we_o;
      aluoutODD     = vt[i].a_o;
      writedataODD  = vt[i].d_o;
      if (vt[i].ck_e) push($sformatf("v%0d_rdE", i), vt[i].x_re);
      push($sformatf("v%0d_rdO", i), vt[i].x_ro);
      push($sformatf("v%0d_selE", i), 32'(vt[i].x_se));
      push($sformatf("v%0d_selO", i), 32'(vt[i].x_so));
      push($sformatf("v%0d_ledr", i), 32'(vt[i].x_led));
      push($sformatf("v%0d_ledrE", i), 32'(vt[i].x_le));
      push($sformatf("v%0d_ledrO", i), 32'(vt[i].x_lo));
      #2;
      if (vt[i].ck_e) pop_cmp(readioEVEN);
      pop_cmp(readioODD);
      pop_cmp(32'(ioselEVEN));
      pop_cmp(32'(ioselODD));
      pop_cmp(32'(ledr));
      pop_cmp(32'(ledrEVEN));
      pop_cmp(32'(ledrODD));
      step();
    end
    idle();

    sw = 4'h5;
    step();
    rd_e("sw_k", A_SW, 32'hA);
    step();
    rd_e("sw_k1", A_SW, 32'h5);

    key = 1'b0;
    repeat (3) step();
    key = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_e($sformatf("glitch%0d", i), A_KEY, 0);
      step();
    end

    key = 1'b0;
    step();
    for (int i = 0; i < DB + 1; i++) begin
      rd_e($sformatf("press_wait%0d", i), A_KEY, 0);
      step();
    end
    rd_e("press", A_KEY, 3);
    memwriteEVEN  = 1'b1;
    writedataEVEN = 32'h2;
    aluoutODD     = A_KEY;
    #1;
    chk("clr_fwdO", readioODD, 1);
    chk("clr_rdE", readioEVEN, 3);
    step();
    idle();
    rd_e("cleared", A_KEY, 1);
    repeat (3) step();
    rd_e("held", A_KEY, 1);

    key = 1'b1;
    step();
    for (int i = 0; i < DB + 1; i++) begin
      rd_e($sformatf("rel_wait%0d", i), A_KEY, 1);
      step();
    end
    rd_e("released", A_KEY, 0);

    key = 1'b0;
    step();
    for (int i = 0; i < DB; i++) begin
      rd_e($sformatf("sw_wait%0d", i), A_KEY, 0);
      step();
    end
    memwriteEVEN  = 1'b1;
    aluoutEVEN    = A_KEY;
    writedataEVEN = 32'h2;
    step();
    idle();
    rd_e("set_wins", A_KEY, 3);

    memwriteEVEN  = 1'b1;
    aluoutEVEN    = A_LED;
    writedataEVEN = 32'hFFFF;
    memwriteODD   = 1'b1;
    aluoutODD     = A_CYC;
    writedataODD  = 32'd500;
    step();
    idle();
    chk("pre_ledr", 32'(ledr), 32'hFFFF);
    rd_e("pre_cyc", A_CYC, 32'd500);
    key = 1'b1;
    step();
    step();
    rd_e("pre_cyc2", A_CYC, 32'd502);
    reset = 1'b1;
    #1;
    chk("mid_ledr", 32'(ledr), 0);
    chk("mid_ledrE", 32'(ledrEVEN), 0);
    chk("mid_ledrO", 32'(ledrODD), 0);
    rd_e("mid_cyc", A_CYC, 0);
    rd_e("mid_key", A_KEY, 0);
    step();
    step();
    reset = 1'b0;
    rd_e("post_cyc0", A_CYC, 0);
    step();
    rd_e("post_cyc1", A_CYC, 1);
    rd_e("post_key", A_KEY, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
